display_scan: RTL and testbench
===============================

DISPLAY_SCAN -- requirements
Module: display_scan

Interface
REQ-001 Parameter REFRESH_DIV, 100000, clock cycles per digit slot; legal range is 2 or more.
REQ-002 Parameter DEADTIME, 16, cycles at slot start with all anodes off; legal range is 1 to REFRESH_DIV-1.
REQ-003 Parameter BLINK_FRAMES, 64, full scan frames per blink half-period; legal range is 1 or more.
REQ-004 clock  input  1  sole clock; all state updates on rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 d1..d8  input  6 each  display codes from the game FSM (d1 = leftmost digit).
REQ-007 blink  input  1  1 = flash the whole display (tied to p1_win|p2_win).
REQ-008 an  output  8  anode enables, active-low; dN drives an[8-N].
REQ-009 seg  output  7  segments {g,f,e,d,c,b,a}, active-low.
REQ-010 dp  output  1  decimal point, active-low; always 1 (off) in this block.

Function
REQ-011 Slot counter cnt counts 0..REFRESH_DIV-1 and wraps; digit index idx (0..7, idx 0 = d1) advances on cnt wrap, with 7 wrapping to 0.
REQ-012 On every cycle with cnt==0 and idx==0, including the first cycle after reset, all eight codes are captured into a frame snapshot; mid-frame input changes are not shown until the next frame.
REQ-013 Code decode: {0,v,0} for v=0..9 shows digit v; 111111 is dash (g only); 001101 is G; 011111 and 011110 are U; 011011 and 111011 are S; 010101 is P; 000011 is 1; 000101 is 2; 111101 and 011101 are E; 011001 is c; 010111 is b; any other code is blank (all segments off).
REQ-014 Outputs are registered from (cnt, idx, snapshot, phase): exactly one cycle of latency, and no combinational path from any input to any output.
REQ-015 For cnt < DEADTIME, an = 8'hFF; for cnt >= DEADTIME and phase on, only the anode of idx is low and seg shows the decoded snapshot code of idx.
REQ-016 At most one anode is low in any cycle.
REQ-017 Blink: a frame counter increments on each frame end (cnt wrap with idx==7); on reaching BLINK_FRAMES it clears and phase toggles.
REQ-018 While blink==0, the frame counter is held at 0 and phase is forced on.
REQ-019 When blink rises, phase stays on for the first BLINK_FRAMES frames, then goes off.
REQ-020 With phase off, an = 8'hFF and seg = 7'h7F; the scan counters keep running.
REQ-021 A blink change in the same cycle as a frame end: the new blink value takes priority, so blink==0 clears the frame counter and forces phase on.

Reset
REQ-022 Reset sets cnt=0, idx=0, frame counter=0 and phase=on.
REQ-023 Reset sets the snapshot to all 111111 and sets an=8'hFF, seg=7'h7F, dp=1 on the next edge.
REQ-024 Reset asserted mid-slot or mid-blink overrides everything within one cycle; the scan restarts at d1 with a fresh capture.

Structure
REQ-025 Shared package bc_pkg holds the 6-bit code constants (DASH, G, U, S, P, E, C, B, ONE, TWO) and the digit code layout.
REQ-026 Combinational sub-module seg_decode (6-bit code to 7 active-low segments, per REQ-013) is instantiated once, on the selected snapshot code.
REQ-027 The scan counters, snapshot registers, blink logic and output registers reside in display_scan.

Verification (REFRESH_DIV=8, DEADTIME=2, BLINK_FRAMES=2)
REQ-028 Reset release with d1..d8=000000 -> an==FF for 3 cycles, then an==7F and seg==1000000 (digit 0) for 6 cycles, then an==FF for 2 cycles, then an==BF.
REQ-029 Walk d1..d8 = 0..7 as {0,v,0} -> each slot shows its digit on the correct anode in order; wrap back to an==7F after 64 cycles.
REQ-030 Change d3 from 000100 to 111111 in the middle of slot 3 -> digit 2 is still shown in that frame; dash (seg==0111111) is shown in the next frame.
REQ-031 Codes 001101, 101010 and 111011 -> G pattern, blank (7F) and S pattern respectively.
REQ-032 Assert blink -> 2 frames lit, 2 frames an==FF, repeating; deassert during an off frame -> lit on the next cycle.
REQ-033 Assert reset during cnt=5, idx=4 -> an==FF and idx restarts at 0; no anode is low during reset.

Source files
------------

// File: rtl/bc_pkg.sv
// Display code constants, code layout and small helpers shared by the
// display scanner and its segment decoder.
package bc_pkg;

    // Non-numeric glyph codes driven by the game FSM
    localparam logic [5:0] DASH  = 6'b111111;
    localparam logic [5:0] G     = 6'b001101;
    localparam logic [5:0] U     = 6'b011111;
    localparam logic [5:0] U_ALT = 6'b011110;
    localparam logic [5:0] S     = 6'b011011;
    localparam logic [5:0] S_ALT = 6'b111011;
    localparam logic [5:0] P     = 6'b010101;
    localparam logic [5:0] ONE   = 6'b000011;
    localparam logic [5:0] TWO   = 6'b000101;
    localparam logic [5:0] E     = 6'b111101;
    localparam logic [5:0] E_ALT = 6'b011101;
    localparam logic [5:0] C     = 6'b011001;
    localparam logic [5:0] B     = 6'b010111;

    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [7:0] AN_OFF    = 8'hFF;

    // Numeric digits are encoded as {0, value, 0}
    typedef struct packed {
        logic       hi;
        logic [3:0] val;
        logic       lo;
    } code_t;

    typedef enum logic {
        PHASE_OFF = 1'b0,
        PHASE_ON  = 1'b1
    } phase_e;

    function automatic logic is_digit(input logic [5:0] f_code);
        code_t w_c;
        w_c = f_code;
        return !w_c.hi && !w_c.lo && (w_c.val <= 4'd9);
    endfunction

    function automatic logic [3:0] digit_val(input logic [5:0] f_code);
        code_t w_c;
        w_c = f_code;
        return w_c.val;
    endfunction

endpackage

// File: rtl/seg_decode.sv
// Combinational decode of a 6-bit display code into active-low segments
// ordered {g,f,e,d,c,b,a}; unknown codes blank the digit.
module seg_decode
    import bc_pkg::*;
(
    input  logic [5:0] i_code,
    output logic [6:0] o_seg
);

    always_comb begin
        o_seg = SEG_BLANK;
        if (is_digit(i_code)) begin
            case (digit_val(i_code))
                4'd0:    o_seg = 7'b1000000;
                4'd1:    o_seg = 7'b1111001;
                4'd2:    o_seg = 7'b0100100;
                4'd3:    o_seg = 7'b0110000;
                4'd4:    o_seg = 7'b0011001;
                4'd5:    o_seg = 7'b0010010;
                4'd6:    o_seg = 7'b0000010;
                4'd7:    o_seg = 7'b1111000;
                4'd8:    o_seg = 7'b0000000;
                4'd9:    o_seg = 7'b0010000;
                default: o_seg = SEG_BLANK;
            endcase
        end else begin
            case (i_code)
                DASH:     o_seg = 7'b0111111;
                G:        o_seg = 7'b1000010;
                U, U_ALT: o_seg = 7'b1000001;
                S, S_ALT: o_seg = 7'b0010010;
                P:        o_seg = 7'b0001100;
                ONE:      o_seg = 7'b1111001;
                TWO:      o_seg = 7'b0100100;
                E, E_ALT: o_seg = 7'b0000110;
                C:        o_seg = 7'b0100111;
                B:        o_seg = 7'b0000011;
                default:  o_seg = SEG_BLANK;
            endcase
        end
    end

endmodule

// File: rtl/display_scan.sv
// Eight-digit multiplexed display scanner with per-frame input snapshot,
// anode dead-time at each slot start and whole-display blinking.
module display_scan
    import bc_pkg::*;
#(
    parameter int unsigned REFRESH_DIV  = 100000,
    parameter int unsigned DEADTIME     = 16,
    parameter int unsigned BLINK_FRAMES = 64
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [5:0] d1,
    input  logic [5:0] d2,
    input  logic [5:0] d3,
    input  logic [5:0] d4,
    input  logic [5:0] d5,
    input  logic [5:0] d6,
    input  logic [5:0] d7,
    input  logic [5:0] d8,
    input  logic       blink,
    output logic [7:0] an,
    output logic [6:0] seg,
    output logic       dp
);

    localparam int unsigned CNT_W = $clog2(REFRESH_DIV);
    localparam int unsigned FR_W  = $clog2(BLINK_FRAMES + 1);

    logic [CNT_W-1:0] r_cnt;
    logic [2:0]       r_idx;
    logic [FR_W-1:0]  r_frames;
    phase_e           r_phase;
    logic [5:0]       r_snap [8];
    logic [7:0]       r_an;
    logic [6:0]       r_seg;

    logic [5:0]       w_din [8];
    logic             w_slot_end;
    logic             w_frame_end;
    logic             w_capture;
    logic             w_lit;
    logic [6:0]       w_seg;

    assign w_din       = '{d1, d2, d3, d4, d5, d6, d7, d8};
    assign w_slot_end  = (r_cnt == CNT_W'(REFRESH_DIV - 1));
    assign w_frame_end = w_slot_end && (r_idx == 3'd7);
    assign w_capture   = (r_cnt == '0) && (r_idx == '0);

    // A low blink forces the display on without waiting for r_phase to update
    assign w_lit = (r_cnt >= CNT_W'(DEADTIME)) && ((r_phase == PHASE_ON) || !blink);

    seg_decode u_seg_decode (
        .i_code (r_snap[r_idx]),
        .o_seg  (w_seg)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            r_cnt    <= '0;
            r_idx    <= '0;
            r_frames <= '0;
            r_phase  <= PHASE_ON;
            r_snap   <= '{default: DASH};
            r_an     <= AN_OFF;
            r_seg    <= SEG_BLANK;
        end else begin
            if (w_slot_end) begin
                r_cnt <= '0;
                r_idx <= r_idx + 3'd1;
            end else begin
                r_cnt <= r_cnt + CNT_W'(1);
            end

            if (w_capture) begin
                r_snap <= w_din;
            end

            if (!blink) begin
                r_frames <= '0;
                r_phase  <= PHASE_ON;
            end else if (w_frame_end) begin
                if (r_frames == FR_W'(BLINK_FRAMES - 1)) begin
                    r_frames <= '0;
                    r_phase  <= (r_phase == PHASE_ON) ? PHASE_OFF : PHASE_ON;
                end else begin
                    r_frames <= r_frames + FR_W'(1);
                end
            end

            // Anode for dN is an[8-N], i.e. bit 7-idx
            r_an  <= w_lit ? ~(8'h80 >> r_idx) : AN_OFF;
            r_seg <= w_lit ? w_seg : SEG_BLANK;
        end
    end

    assign an  = r_an;
    assign seg = r_seg;
    assign dp  = 1'b1;

endmodule

// File: tb/tb_display_scan.sv
// Randomized and directed bench for display_scan against a frame-level
// reference model (scan position, frames since blink rise, glyph tables).
module tb_display_scan;

    localparam int RD = 8;
    localparam int DT = 2;
    localparam int BF = 2;
    localparam int FRAME = 8 * RD;

    logic       clk;
    logic       reset;
    logic [5:0] d [8];
    logic       blink;
    logic [7:0] an;
    logic [6:0] seg;
    logic       dp;

    int n_checks;
    int n_pass;

    // Reference model state: scan position within a frame, frames completed
    // since blink rose, and the frame snapshot.
    int         p;
    int         k;
    logic [5:0] msnap [8];

    display_scan #(
        .REFRESH_DIV  (RD),
        .DEADTIME     (DT),
        .BLINK_FRAMES (BF)
    ) dut (
        .clock (clk),
        .reset (reset),
        .d1    (d[0]),
        .d2    (d[1]),
        .d3    (d[2]),
        .d4    (d[3]),
        .d5    (d[4]),
        .d6    (d[5]),
        .d7    (d[6]),
        .d8    (d[7]),
        .blink (blink),
        .an    (an),
        .seg   (seg),
        .dp    (dp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %02h expected %02h (t=%0t)", tag, got, exp, $time);
    endtask

    // Lit segments per glyph, by segment letter
    function automatic string glyph_lit(input logic [5:0] code);
        if (code[5] == 1'b0 && code[0] == 1'b0 && code[4:1] <= 4'd9) begin
            case (code[4:1])
                4'd0: return "abcdef";
                4'd1: return "bc";
                4'd2: return "abdeg";
                4'd3: return "abcdg";
                4'd4: return "bcfg";
                4'd5: return "acdfg";
                4'd6: return "acdefg";
                4'd7: return "abc";
                4'd8: return "abcdefg";
                default: return "abcdfg";
            endcase
        end
        case (code)
            6'b111111:            return "g";
            6'b001101:            return "acdef";
            6'b011111, 6'b011110: return "bcdef";
            6'b011011, 6'b111011: return "acdfg";
            6'b010101:            return "abefg";
            6'b000011:            return "bc";
            6'b000101:            return "abdeg";
            6'b111101, 6'b011101: return "adefg";
            6'b011001:            return "deg";
            6'b010111:            return "cdefg";
            default:              return "";
        endcase
    endfunction

    function automatic logic [6:0] ref_seg(input logic [5:0] code);
        string      lit;
        logic [6:0] s;
        lit = glyph_lit(code);
        s = 7'h7F;
        for (int i = 0; i < lit.len(); i++) s[int'(lit[i]) - 97] = 1'b0;
        return s;
    endfunction

    task automatic tick();
        int         cnt;
        int         idx;
        logic       lit;
        logic [7:0] ea;
        logic [6:0] es;
        if (reset) begin
            ea = 8'hFF;
            es = 7'h7F;
        end else begin
            cnt = p % RD;
            idx = p / RD;
            lit = (cnt >= DT) && (!blink || ((k / BF) % 2 == 0));
            ea = 8'hFF;
            es = 7'h7F;
            if (lit) begin
                ea[7 - idx] = 1'b0;
                es = ref_seg(msnap[idx]);
            end
        end

        if (reset) begin
            p = 0;
            k = 0;
            for (int i = 0; i < 8; i++) msnap[i] = 6'b111111;
        end else begin
            if (p == 0) msnap = d;
            if (!blink) k = 0;
            else if (p == FRAME - 1) k++;
            p = (p + 1) % FRAME;
        end

        @(posedge clk);
        #1;
        check("an", an, ea);
        check("seg", {1'b0, seg}, {1'b0, es});
        check("dp", {7'b0, dp}, 8'd1);
        check("an_onehot", {7'b0, ($countones(~an) <= 1)}, 8'd1);
    endtask

    task automatic run_to(input int target);
        int guard;
        guard = 0;
        while (p != target && guard < 2 * FRAME) begin
            tick();
            guard++;
        end
        check("run_to", {7'b0, (p == target)}, 8'd1);
    endtask

    logic [7:0] exp28 [11];
    logic [5:0] pool [16];

    initial begin
        n_checks = 0;
        n_pass   = 0;
        p = 0;
        k = 0;
        reset = 1'b1;
        blink = 1'b0;
        for (int i = 0; i < 8; i++) d[i] = 6'b000000;
        exp28 = '{8'hFF, 8'hFF, 8'h7F, 8'h7F, 8'h7F, 8'h7F, 8'h7F, 8'h7F,
                  8'hFF, 8'hFF, 8'hBF};
        pool = '{6'b111111, 6'b001101, 6'b011111, 6'b011110, 6'b011011, 6'b111011,
                 6'b010101, 6'b000011, 6'b000101, 6'b111101, 6'b011101, 6'b011001,
                 6'b010111, 6'b101010, 6'b010010, 6'b000110};

        repeat (3) tick();
        reset = 1'b0;

        // Reset release timing with all-zero codes
        for (int i = 0; i < 11; i++) begin
            tick();
            check("rel_an", an, exp28[i]);
            if (exp28[i] == 8'h7F) check("rel_seg", {1'b0, seg}, 8'h40);
        end

        // Digit walk 0..7
        run_to(0);
        for (int i = 0; i < 8; i++) d[i] = {1'b0, 4'(i), 1'b0};
        repeat (2 * FRAME + 4) tick();

        // Mid-frame change of d3 is deferred to the next frame
        run_to(2 * RD + 4);
        d[2] = 6'b111111;
        repeat (2 * FRAME) tick();

        // G, blank, S
        d[0] = 6'b001101;
        d[1] = 6'b101010;
        d[2] = 6'b111011;
        run_to(0);
        repeat (2 * FRAME) tick();

        // Blink, released during an off frame
        run_to(0);
        blink = 1'b1;
        repeat (3 * FRAME + 20) tick();
        blink = 1'b0;
        repeat (30) tick();

        // Blink falls on a frame end
        blink = 1'b1;
        run_to(FRAME - 1);
        blink = 1'b0;
        repeat (RD + 4) tick();

        // Reset mid-slot while blinking
        blink = 1'b1;
        run_to(4 * RD + 5);
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        repeat (FRAME + 6) tick();

        // Random traffic
        for (int n = 0; n < 4000; n++) begin
            if ($urandom_range(39) == 0) begin
                if ($urandom_range(1) == 0) d[$urandom_range(7)] = pool[$urandom_range(15)];
                else d[$urandom_range(7)] = 6'($urandom);
            end
            if ($urandom_range(149) == 0) blink = ~blink;
            reset = ($urandom_range(499) == 0);
            tick();
        end
        reset = 1'b0;
        tick();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
